// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the inter-stage pipeline registers.
//   - state_e      : occupancy FSM of a pipeline stage register
//   - bundle widths: control sub-fields (WB/MEM/EX) and data fields (PC,
//                    operands, immediate, register ids)
//   - occ_of()     : maps a state to the 2-bit occupancy count it represents
// -----------------------------------------------------------------------------
package pipe_pkg;

    // The encodings are chosen so that a state equals its entry count. The
    // occupancy output is then a plain copy of the state register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Control bundle sub-fields.
    localparam int CTL_WB_W  = 2;
    localparam int CTL_MEM_W = 3;
    localparam int CTL_EX_W  = 4;

    // Data bundle fields.
    localparam int REG_ID_W  = 5;
    localparam int WORD_W    = 32;

    // Default bundle widths. These match the ID/EX register, which is the
    // widest stage: PC, rs1 value, rs2 value and imm are words, plus two
    // register ids.
    localparam int CTL_W_DEF  = CTL_WB_W + CTL_MEM_W + CTL_EX_W;
    localparam int DATA_W_DEF = 4 * WORD_W + 2 * REG_ID_W;

    function automatic logic [1:0] occ_of(input state_e s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Generic pipeline register between two core stages, such as IF/ID, ID/EX,
// EX/MEM and MEM/WB. It uses a valid/ready handshake. An optional second
// (skid) entry lets in_ready be a register, so no combinational path runs
// from out_ready back upstream. The register inserts a bubble automatically:
// out_ctl is zero whenever the stage holds nothing. A dead stage therefore
// never writes the register file or memory.
//
// Parameters
//   CTL_W    width of the control bundle (zeroed in bubbles)
//   DATA_W   width of the data bundle (holds its last value in bubbles)
//   SKID_EN  1: two entries, in_ready registered
//            0: one entry, in_ready = !out_valid | out_ready
//
// Ports
//   clk        clock. All state updates on the FALLING edge.
//   rst        asynchronous active-high reset
//   flush      kills every held entry and any entry offered on this edge
//   in_valid   upstream offers an instruction
//   in_ready   the stage can accept on the coming edge
//   in_ctl     upstream control bundle
//   in_data    upstream data bundle
//   out_valid  out_ctl/out_data carry a live instruction
//   out_ready  downstream accepts (0 = stall)
//   out_ctl    control bundle to the next stage
//   out_data   data bundle to the next stage
//   occupancy  number of entries held (0, 1, 2)
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTL_W   = CTL_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SKID_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTL_W-1:0]  in_ctl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTL_W-1:0]  out_ctl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [CTL_W-1:0]    main_ctl_q, main_ctl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTL_W-1:0]    skid_ctl_q;
    logic [DATA_W-1:0]   skid_data_q;
    logic                skid_load;

    logic                accept;
    logic                emit;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid_q & out_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // The main register is loaded only on a real accept, or from the skid
    // entry. An undriven or X bundle offered while in_valid=0 can therefore
    // never reach the outputs. Every path into EMPTY clears the control
    // bundle, which forms the bubble. The data bundle is left alone so that
    // the wide bus does not toggle.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        main_ctl_d  = main_ctl_q;
        main_data_d = main_data_q;
        skid_load   = 1'b0;

        if (flush) begin
            // The flush overrides the handshake entirely. Whatever is held and
            // whatever is offered on this edge is discarded.
            state_d    = ST_EMPTY;
            main_ctl_d = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        main_ctl_d  = in_ctl;
                        main_data_d = in_data;
                    end
                end

                ST_ONE: begin
                    if (emit && accept) begin
                        // Swap through: the old entry leaves as the new one
                        // arrives.
                        main_ctl_d  = in_ctl;
                        main_data_d = in_data;
                    end else if (emit) begin
                        state_d    = ST_EMPTY;
                        main_ctl_d = '0;
                    end else if (accept && (SKID_EN != 0)) begin
                        // Downstream is stalled. Park the newcomer behind the
                        // main entry so that order is preserved. Without a
                        // skid, in_ready already follows out_ready, so an
                        // accept-only edge cannot occur here.
                        state_d   = ST_TWO;
                        skid_load = 1'b1;
                    end
                end

                ST_TWO: begin
                    // in_ready is low in this state, so only a drain can happen.
                    if (emit) begin
                        state_d     = ST_ONE;
                        main_ctl_d  = skid_ctl_q;
                        main_data_d = skid_data_q;
                    end
                end

                default: begin
                    state_d    = ST_EMPTY;
                    main_ctl_d = '0;
                end
            endcase
        end

        out_valid_d = (state_d != ST_EMPTY);
    end

    // -------------------------------------------------------------------------
    // Main entry and FSM registers (falling-edge pipeline timing)
    // -------------------------------------------------------------------------
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            main_ctl_q  <= '0;
            main_data_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            main_ctl_q  <= main_ctl_d;
            main_data_q <= main_data_d;
        end
    end

    // -------------------------------------------------------------------------
    // Skid entry and in_ready
    // -------------------------------------------------------------------------
    generate
        if (SKID_EN != 0) begin : g_skid
            logic in_ready_q;

            // in_ready comes straight from a flop that is computed from the
            // next state. It therefore always equals (state != TWO) and has no
            // same-cycle dependence on out_ready.
            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    skid_ctl_q  <= '0;
                    skid_data_q <= '0;
                    in_ready_q  <= 1'b1;
                end else begin
                    if (skid_load) begin
                        skid_ctl_q  <= in_ctl;
                        skid_data_q <= in_data;
                    end
                    in_ready_q <= (state_d != ST_TWO);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_no_skid
            logic skid_load_unused;

            assign skid_load_unused = skid_load;
            assign skid_ctl_q       = '0;
            assign skid_data_q      = '0;

            // With a single entry, the stage may take a new instruction only
            // if it is empty or its current one leaves on the same edge.
            assign in_ready = ~out_valid_q | out_ready;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_valid = out_valid_q;
    assign out_ctl   = main_ctl_q;
    assign out_data  = main_data_q;
    assign occupancy = occ_of(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Drives one stimulus stream into two instances: one with a skid entry and one
// without. The DUTs update on the falling clock edge. Inputs change just after
// a falling edge. Handshakes are observed on the rising edge, midway between
// updates. Each entry a DUT accepts is queued per instance. A monitor pops and
// compares the queue whenever that DUT emits.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int CW = CTL_W_DEF;
    localparam int DW = DATA_W_DEF;
    localparam int IW = CW + DW;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctl    = '0;
    logic [DW-1:0] in_data   = '0;

    logic          in_ready1, out_valid1, in_ready0, out_valid0;
    logic [CW-1:0] out_ctl1, out_ctl0;
    logic [DW-1:0] out_data1, out_data0;
    logic [1:0]    occ1, occ0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [IW-1:0] q1[$];
    logic [IW-1:0] q0[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTL_W(CW), .DATA_W(DW), .SKID_EN(1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_ctl(in_ctl), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctl(out_ctl1), .out_data(out_data1),
        .occupancy(occ1)
    );

    pipe_stage_reg #(.CTL_W(CW), .DATA_W(DW), .SKID_EN(0)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_ctl(in_ctl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctl(out_ctl0), .out_data(out_data0),
        .occupancy(occ0)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Offers instruction k: ctl=k (nonzero for live entries), data=k.
    task automatic offer(input bit v, input int unsigned k);
        in_valid = v;
        in_ctl   = CW'(k);
        in_data  = DW'(k);
    endtask

    // Lets one update edge pass. Accepted entries are queued at the rising
    // edge that precedes the update.
    task automatic edge_step();
        @(posedge clk);
        if (!rst && !flush && in_valid) begin
            if (in_ready1) q1.push_back({in_ctl, in_data});
            if (in_ready0) q0.push_back({in_ctl, in_data});
        end
        @(negedge clk);
        #1;
        $display("t=%0t iv=%0b or=%0b fl=%0b | skid: ov=%0b occ=%0d d=%0h | noskid: ov=%0b occ=%0d d=%0h",
                 $time, in_valid, out_ready, flush, out_valid1, occ1, out_data1, out_valid0, occ0, out_data0);
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(posedge clk) begin
        logic [IW-1:0] e;
        if (!rst) begin
            if (flush) begin
                q1.delete();
            end else if (out_valid1 && out_ready) begin
                if (q1.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL sb_skid_spurious: emitted %0h with nothing expected", out_data1);
                end else begin
                    e = q1.pop_front();
                    chk("sb_skid_item", {out_ctl1, out_data1}, e);
                end
            end
            if (!out_valid1) chk("sb_skid_bubble_ctl", out_ctl1, 0);

            if (flush) begin
                q0.delete();
            end else if (out_valid0 && out_ready) begin
                if (q0.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL sb_noskid_spurious: emitted %0h with nothing expected", out_data0);
                end else begin
                    e = q0.pop_front();
                    chk("sb_noskid_item", {out_ctl0, out_data0}, e);
                end
            end
            if (!out_valid0) chk("sb_noskid_bubble_ctl", out_ctl0, 0);
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            chk("sb_skid_occ", occ1, q1.size());
            chk("sb_skid_valid", out_valid1, q1.size() != 0);
            chk("sb_noskid_occ", occ0, q0.size());
            chk("sb_noskid_valid", out_valid0, q0.size() != 0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_valid", out_valid1, 0);
        chk("rst_ctl", out_ctl1, 0);
        chk("rst_data", out_data1, 0);
        chk("rst_occ", occ1, 0);
        chk("rst_in_ready", in_ready1, 1);
        chk("rst_in_ready_noskid", in_ready0, 1);
        @(negedge clk);
        #1 rst = 1'b0;

        // Test 2: streaming, one edge latency, no gaps.
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            offer(1'b1, k);
            edge_step();
            chk("stream_data", out_data1, k);
            chk("stream_occ", occ1, 1);
            chk("stream_valid", out_valid1, 1);
            chk("stream_data_noskid", out_data0, k);
        end
        offer(1'b0, 0);
        edge_step();
        chk("stream_drain_occ", occ1, 0);
        edge_step();

        // Test 3: stall at ONE. B goes into the skid entry, then A and B drain in order.
        out_ready = 1'b0;
        offer(1'b1, 'hA1);
        edge_step();
        chk("skid_occ1", occ1, 1);
        chk("skid_dataA", out_data1, 'hA1);
        offer(1'b1, 'hB2);
        edge_step();
        chk("skid_occ2", occ1, 2);
        chk("skid_in_ready", in_ready1, 0);
        chk("skid_hold_A", out_data1, 'hA1);
        chk("noskid_hold_A", out_data0, 'hA1);
        offer(1'b0, 0);
        out_ready = 1'b1;
        edge_step();
        chk("skid_release_B", out_data1, 'hB2);
        chk("skid_release_occ", occ1, 1);
        edge_step();
        chk("skid_empty", occ1, 0);

        // Test 1: asynchronous reset pulse while in TWO.
        out_ready = 1'b0;
        offer(1'b1, 'hC1);
        edge_step();
        offer(1'b1, 'hC2);
        edge_step();
        chk("pre_rst_occ", occ1, 2);
        offer(1'b0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        q1.delete();
        q0.delete();
        #1;
        chk("midrst_valid", out_valid1, 0);
        chk("midrst_ctl", out_ctl1, 0);
        chk("midrst_data", out_data1, 0);
        chk("midrst_occ", occ1, 0);
        chk("midrst_in_ready", in_ready1, 1);
        chk("midrst_occ_noskid", occ0, 0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Test 4: flush at TWO with C offered. C is dropped.
        out_ready = 1'b0;
        offer(1'b1, 'hD1);
        edge_step();
        offer(1'b1, 'hD2);
        edge_step();
        offer(1'b1, 'hCC);
        flush = 1'b1;
        edge_step();
        chk("flush_occ", occ1, 0);
        chk("flush_valid", out_valid1, 0);
        chk("flush_ctl", out_ctl1, 0);
        chk("flush_ctl_noskid", out_ctl0, 0);
        flush = 1'b0;
        offer(1'b0, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_step();
            chk("flush_nothing_out", out_valid1, 0);
        end

        // Test 5: without a skid entry, in_ready follows out_ready in the same cycle.
        offer(1'b1, 'hF1);
        edge_step();
        out_ready = 1'b0;
        offer(1'b1, 'h61);
        #1;
        chk("noskid_in_ready_stall", in_ready0, 0);
        chk("skid_in_ready_stall", in_ready1, 1);
        edge_step();
        chk("noskid_hold_F", out_data0, 'hF1);
        chk("noskid_occ_hold", occ0, 1);
        out_ready = 1'b1;
        #1;
        chk("noskid_in_ready_go", in_ready0, 1);
        edge_step();
        chk("noskid_swap", out_data0, 'h61);
        chk("noskid_swap_occ", occ0, 1);
        chk("skid_drain_G", out_data1, 'h61);
        offer(1'b0, 0);
        edge_step();
        edge_step();

        // Test 6: random valid/ready/flush against the scoreboard.
        for (int i = 0; i < 10000; i++) begin
            flush     = ($urandom_range(0, 99) < 3);
            out_ready = ($urandom_range(0, 9) < 6);
            in_valid  = ($urandom_range(0, 9) < 7);
            if (in_valid) begin
                in_ctl  = CW'($urandom_range(1, (1 << CW) - 1));
                in_data = DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
            end else begin
                in_ctl  = 'x;
                in_data = 'x;
            end
            edge_step();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        offer(1'b0, 0);
        for (int i = 0; i < 4; i++) edge_step();
        chk("final_q_skid_empty", q1.size(), 0);
        chk("final_q_noskid_empty", q0.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
